multdiv_sequencer: RTL and testbench

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

---
 rtl/multdiv_sequencer.sv | 163 ++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// ============================================================================
// Module   : multdiv_sequencer
// Purpose  : Sequences a multi-cycle multiply/divide operation. It latches the
//            X-stage request, pulses the multdiv unit, waits for its result,
//            then arbitrates for the register-file write port against M/W.
//            It also generates pipeline stalls for structural and RAW hazards.
// Options  : `define MULTDIV_SEQUENCER_WATCHDOG_EN adds a 6-bit RUN watchdog
//            that forces an exception writeback after 48 RUN cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_mult,
  input  logic        issue_div,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  fd_rs_a,
  input  logic [4:0]  fd_rs_b,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_in_a,
  output logic [31:0] md_in_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  input  logic        mw_we,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_WB    = 2'd3
  } state_t;

  localparam logic [4:0]  C_RSTATUS_REG = 5'd30;
  localparam logic [31:0] C_MULT_EXC    = 32'd4;
  localparam logic [31:0] C_DIV_EXC     = 32'd5;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_op;          // 0 = mult, 1 = div
  logic [4:0]  r_rd;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic        r_exc;
  logic        w_issue;
  logic        w_wb_needed;
  logic        w_timeout;
  logic        w_raw_hazard;

  assign w_issue     = issue_mult | issue_div;
  // A write to r0 is pointless unless it is the redirected rstatus write.
  assign w_wb_needed = r_exc | (r_rd != 5'd0);
  assign md_in_a     = r_a;
  assign md_in_b     = r_b;

`ifdef MULTDIV_SEQUENCER_WATCHDOG_EN
  localparam logic [5:0] C_WD_LAST = 6'd47;
  logic [5:0] r_wd_cnt;

  // Count RUN cycles; cleared in START so the count begins at zero on RUN entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   r_wd_cnt <= '0;
    else if (r_state == S_START) r_wd_cnt <= '0;
    else if (r_state == S_RUN)   r_wd_cnt <= r_wd_cnt + 6'd1;
  end

  // The 48th RUN cycle without md_ready ends the wait (count reaches 48)
  assign w_timeout = (r_state == S_RUN) && !md_ready && (r_wd_cnt == C_WD_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and output decode
  always_comb begin
    w_state_next = r_state;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    wb_valid     = 1'b0;
    wb_reg       = 5'd0;
    wb_data      = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_issue) w_state_next = S_START;
      end
      S_START: begin
        md_ctrl_mult = ~r_op;
        md_ctrl_div  = r_op;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        if (md_ready || w_timeout) w_state_next = S_WB;
      end
      S_WB: begin
        wb_reg   = r_exc ? C_RSTATUS_REG : r_rd;
        wb_data  = r_exc ? (r_op ? C_DIV_EXC : C_MULT_EXC) : r_result;
        // M/W always owns the port when it wants it
        wb_valid = w_wb_needed & ~mw_we;
        if (!w_wb_needed || !mw_we) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    busy = (r_state != S_IDLE);
    // The RAW term drops on the write cycle: the regfile writes before it reads
    w_raw_hazard = busy && (r_rd != 5'd0) &&
                   ((fd_rs_a == r_rd) || (fd_rs_b == r_rd)) && !wb_valid;
    stall = (busy && w_issue) || w_raw_hazard;
  end

  // Operand/result capture; md_ready is only honoured while in RUN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op     <= 1'b0;
      r_rd     <= 5'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_result <= 32'd0;
      r_exc    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_op     <= issue_div;
            r_rd     <= issue_rd;
            r_a      <= issue_a;
            r_b      <= issue_b;
            r_result <= 32'd0;
            r_exc    <= 1'b0;
          end
        end
        S_RUN: begin
          if (md_ready) begin
            r_result <= md_result;
            r_exc    <= md_exception;
          end else if (w_timeout) begin
            r_exc    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
// ============================================================================
// Module   : tb_multdiv_sequencer
// Purpose  : Self-checking bench for multdiv_sequencer. Directed operations
//            push expected write-port transfers into a queue; a monitor pops
//            and compares whenever wb_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_sequencer;

  logic        clock;
  logic        reset;
  logic        issue_mult;
  logic        issue_div;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [4:0]  issue_rd;
  logic [4:0]  fd_rs_a;
  logic [4:0]  fd_rs_b;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_in_a;
  logic [31:0] md_in_b;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;
  logic        mw_we;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        stall;
  logic        busy;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [36:0] exp_q[$];

  multdiv_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .issue_mult   (issue_mult),
    .issue_div    (issue_div),
    .issue_a      (issue_a),
    .issue_b      (issue_b),
    .issue_rd     (issue_rd),
    .fd_rs_a      (fd_rs_a),
    .fd_rs_b      (fd_rs_b),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .md_in_a      (md_in_a),
    .md_in_b      (md_in_b),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_ready     (md_ready),
    .mw_we        (mw_we),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .stall        (stall),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Advance to the next drive point (just after the rising edge)
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: every write-port transfer must match the queue head
  always @(negedge clock) begin
    if (wb_valid) begin
      check("wb_vs_mw_we", {31'd0, mw_we}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL wb_unexpected: got reg %0d data %0h, expected no transfer", wb_reg, wb_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wb_reg", {27'd0, wb_reg}, {27'd0, e[36:32]});
        check("wb_data", wb_data, e[31:0]);
      end
    end
  end

  // One complete operation with hazard checks on fd_rs_a == rd throughout
  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int wait_cyc, input logic [31:0] res,
                        input logic exc, input int mw_hold, input logic exp_valid,
                        input logic [4:0] exp_reg, input logic [31:0] exp_data);
    logic exp_raw;
    exp_raw = (rd != 5'd0);
    step();
    issue_mult = ~is_div; issue_div = is_div;
    issue_a = a; issue_b = b; issue_rd = rd;
    @(negedge clock);
    check("idle_stall", {31'd0, stall}, 32'd0);
    step();
    issue_mult = 1'b0; issue_div = 1'b0; fd_rs_a = rd;
    @(negedge clock);
    check("start_mult", {31'd0, md_ctrl_mult}, {31'd0, ~is_div});
    check("start_div", {31'd0, md_ctrl_div}, {31'd0, is_div});
    check("md_in_a", md_in_a, a);
    check("md_in_b", md_in_b, b);
    check("start_raw_stall", {31'd0, stall}, {31'd0, exp_raw});
    for (int i = 0; i < wait_cyc; i++) begin
      step();
      @(negedge clock);
      if (i == 0) check("run_no_pulse", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
    end
    check("run_raw_stall", {31'd0, stall}, {31'd0, exp_raw});
    step();
    md_ready = 1'b1; md_result = res; md_exception = exc;
    if (exp_valid) exp_q.push_back({exp_reg, exp_data});
    @(negedge clock);
    check("ready_cycle_wb", {31'd0, wb_valid}, 32'd0);
    step();
    md_ready = 1'b0; md_result = 32'hBAD0BAD0; md_exception = 1'b0;
    mw_we = (mw_hold > 0);
    for (int i = 0; i < mw_hold; i++) begin
      @(negedge clock);
      check("hold_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("hold_wb_data", wb_data, exp_data);
      check("hold_raw_stall", {31'd0, stall}, {31'd0, exp_raw});
      step();
      if (i == mw_hold - 1) mw_we = 1'b0;
    end
    @(negedge clock);
    check("wb_valid", {31'd0, wb_valid}, {31'd0, exp_valid});
    check("wb_busy", {31'd0, busy}, 32'd1);
    check("wb_stall", {31'd0, stall}, 32'd0);
    step();
    fd_rs_a = 5'd0;
    @(negedge clock);
    check("done_busy", {31'd0, busy}, 32'd0);
  endtask

  // Global bound on simulation time
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; issue_mult = 1'b0; issue_div = 1'b0;
    issue_a = '0; issue_b = '0; issue_rd = '0; fd_rs_a = '0; fd_rs_b = '0;
    md_result = '0; md_exception = 1'b0; md_ready = 1'b0; mw_we = 1'b0;
    #2 reset = 1'b1;
    @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ctrl", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
    check("rst_wb", {26'd0, wb_valid, wb_reg}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_md_in", md_in_a | md_in_b, 32'd0);
    step();
    reset = 1'b0;

    // 6*7 = 42 into r5, ready after 32 cycles
    run_op(1'b0, 32'd6, 32'd7, 5'd5, 31, 32'd42, 1'b0, 0, 1'b1, 5'd5, 32'd42);
    // div exception redirects to rstatus with code 5
    run_op(1'b1, 32'd100, 32'd0, 5'd3, 4, 32'h1234, 1'b1, 0, 1'b1, 5'd30, 32'd5);
    // port busy for 3 cycles, then one write of 27 into r10
    run_op(1'b0, 32'd3, 32'd9, 5'd10, 2, 32'd27, 1'b0, 3, 1'b1, 5'd10, 32'd27);
    // mult exception redirects with code 4
    run_op(1'b0, 32'd1, 32'd2, 5'd8, 1, 32'd2, 1'b1, 0, 1'b1, 5'd30, 32'd4);
    // rd = 0 without exception: no write at all
    run_op(1'b0, 32'd9, 32'd11, 5'd0, 1, 32'd99, 1'b0, 0, 1'b0, 5'd0, 32'd0);
    // div 20/4 = 5 into r31
    run_op(1'b1, 32'd20, 32'd4, 5'd31, 3, 32'd5, 1'b0, 0, 1'b1, 5'd31, 32'd5);

    // Structural + RAW hazard: second mult waits for the first writeback
    step();
    issue_mult = 1'b1; issue_a = 32'd2; issue_b = 32'd5; issue_rd = 5'd7;
    step();
    issue_mult = 1'b0; fd_rs_a = 5'd7;
    step();
    issue_mult = 1'b1; issue_a = 32'd11; issue_b = 32'd3; issue_rd = 5'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 3) begin
        check("haz_stall", {31'd0, stall}, 32'd1);
        check("haz_md_in_a", md_in_a, 32'd2);
      end
      step();
    end
    md_ready = 1'b1; md_result = 32'd10;
    exp_q.push_back({5'd7, 32'd10});
    @(negedge clock);
    check("haz_ready_stall", {31'd0, stall}, 32'd1);
    step();
    md_ready = 1'b0;
    @(negedge clock);
    check("haz_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("haz_wb_stall", {31'd0, stall}, 32'd1);
    step();
    @(negedge clock);
    check("haz_idle_stall", {31'd0, stall}, 32'd0);
    step();
    issue_mult = 1'b0; fd_rs_a = 5'd0;
    @(negedge clock);
    check("haz_second_start", {31'd0, md_ctrl_mult}, 32'd1);
    check("haz_second_a", md_in_a, 32'd11);
    step();
    md_ready = 1'b1; md_result = 32'd33;
    exp_q.push_back({5'd9, 32'd33});
    step();
    md_ready = 1'b0;
    @(negedge clock);
    check("haz_second_wb", {31'd0, wb_valid}, 32'd1);
    step();

    // Reset mid-RUN, then a stray md_ready
    issue_div = 1'b1; issue_a = 32'd50; issue_b = 32'd7; issue_rd = 5'd4;
    step();
    issue_div = 1'b0; fd_rs_b = 5'd4;
    step(); step(); step();
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_md_in", md_in_a | md_in_b, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    step(); step();
    reset = 1'b0;
    md_ready = 1'b1; md_result = 32'hDEAD; md_exception = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stray_ready_wb", {31'd0, wb_valid}, 32'd0);
      check("stray_ready_busy", {31'd0, busy}, 32'd0);
      step();
    end
    md_ready = 1'b0; md_exception = 1'b0; fd_rs_b = 5'd0;

    // Mult whose unit never answers
    issue_mult = 1'b1; issue_a = 32'd1; issue_b = 32'd1; issue_rd = 5'd12;
    step();
    issue_mult = 1'b0;
`ifdef MULTDIV_SEQUENCER_WATCHDOG_EN
    begin
      int early;
      early = 0;
      exp_q.push_back({5'd30, 32'd4});
      for (int c = 2; c <= 49; c++) begin
        step();
        @(negedge clock);
        if (wb_valid) early++;
      end
      check("wd_no_early_wb", early, 32'd0);
      step();
      @(negedge clock);
      check("wd_wb_valid", {31'd0, wb_valid}, 32'd1);
      step();
      @(negedge clock);
      check("wd_done_busy", {31'd0, busy}, 32'd0);
    end
`else
    for (int c = 2; c <= 100; c++) step();
    @(negedge clock);
    check("no_wd_busy_at_100", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
`endif

    step(); step();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
